exu_md_stage: RTL and testbench
===============================

Name: exu_md_stage

Overview:
- Parametrised successor of the execute stage: one-entry pipeline register between IDU and WBU with valid/ready handshakes on both sides, flush, and a pending-rd scoreboard output.
- Adds what the previous generation lacked: an integrated iterative RV32M multiply/divide unit, generic in XLEN, with configurable multiply throughput.
- Non-M instructions pass through in one cycle with a result precomputed upstream.
- Sits between IDU and WBU; WBU never stalls except via out_ready.

Parameters:
- XLEN, 32, datapath width; must be even and ≥ 8.
- MUL_STEP, 4, multiplier bits retired per cycle; must divide XLEN.
- DIV_EARLY, 1, 1 = divide-by-zero and signed overflow complete without iterating.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill held/in-flight instruction
- in_ready  out  1  stage can accept
- in_valid  in  1  IDU offers instruction
- in_pc  in  XLEN  instruction PC
- in_md  in  1  1 = M-extension op, 0 = pass-through
- in_funct  in  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_val_a  in  XLEN  rs1 value, or the pass-through result
- in_val_b  in  XLEN  rs2 value
- in_rd  in  5  destination register
- out_ready  in  1  WBU accepts
- out_valid  out  1  result available
- out_pc  out  XLEN  PC of the held instruction
- out_rd  out  5  destination register
- out_wdata  out  XLEN  result
- exu_rd  out  5  rd of the held instruction while valid, else 0

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high. Reset → state IDLE, valid = 0, out_valid = 0, exu_rd = 0, counter = 0; the datapath registers are don't-care.
- Accept rule: a transfer happens only when in_valid & in_ready & ~flush. On transfer, latch pc, rd, md, funct, operands, and clear the counter.
- in_ready = (state == IDLE) | (state == DONE & out_ready). This allows back-to-back issue with no bubble.
- States:
  - IDLE: on accept, go to DONE if in_md = 0 or an early case applies; otherwise go to CALC.
  - CALC: counter increments every cycle. Go to DONE when counter reaches XLEN/MUL_STEP − 1 (multiply) or XLEN − 1 (divide).
  - DONE: out_valid = ~flush. On out_ready without a new accept, go to IDLE. On out_ready with a new accept, re-enter per the IDLE rules.
- Latency, counted from the accept edge to the first cycle with out_valid high:
  - pass-through: 1 cycle
  - multiply: XLEN/MUL_STEP + 1 cycles (9 for the defaults)
  - divide: XLEN + 1 cycles (33)
  - early cases: 1 cycle
- Multiply:
  - Operands are sign-extended to XLEN+1 per funct: MULH both signed, MULHSU a signed, MULHU/MUL unsigned (MUL low half is sign-agnostic).
  - Shift-add of MUL_STEP bits per cycle into a 2·XLEN product.
  - MUL returns product[XLEN−1:0]; the other variants return product[2XLEN−1:XLEN].
- Divide:
  - Restoring, 1 quotient bit per cycle, on magnitudes.
  - Signed quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Boundary results (identical whether or not DIV_EARLY is set; only the latency differs):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
- Flush:
  - In any state, the next state is IDLE, valid = 0, and the counter is cleared.
  - out_valid is forced 0 in the flush cycle itself.
  - A simultaneous in_valid is not accepted.
  - Flush while IDLE has no effect.
- Reset mid-CALC aborts the operation identically to flush.
- Stalling: out_* stay stable while out_valid & ~out_ready.
- exu_rd equals the latched rd in CALC and DONE, and is 0 in IDLE.

Decomposition:
- Shared package: md_funct_e enum with the 8 funct3 codes, exu_state_e {IDLE, CALC, DONE}, helper functions is_div(funct) and is_signed_a/b(funct).
- One sub-module, exu_md_iter: the iterative mul/div datapath.
  - Inputs: start, funct, a, b.
  - Outputs: done, result.
  - Holds the counter, partial product/remainder registers, sign fix-up and early-case detection.
  - Stage control, handshake and flush stay in exu_md_stage.

Test Plan:
- Pass-through: in_md = 0, val_a = 0x1234, rd = 5, out_ready = 1 → out_valid the next cycle with wdata 0x1234 and out_rd 5; exu_rd = 5 for exactly 1 cycle.
- MULH: a = 0x80000000, b = 0x80000000 → 0x40000000 after 9 cycles. MULHSU: a = −1, b = 0xFFFFFFFF → 0xFFFFFFFF. MUL: 7 × −3 → 0xFFFFFFEB.
- Divide: DIV −7 / 2 → 0xFFFFFFFD and REM −7 % 2 → 0xFFFFFFFF, each after 33 cycles. DIVU 100 / 0 → 0xFFFFFFFF after 1 cycle; REM 0x80000000 % −1 → 0 after 1 cycle (DIV_EARLY = 1).
- Backpressure: hold out_ready = 0 for 5 cycles after a DIV completes → out_* stable and in_ready = 0. Raise out_ready with a new in_valid → the new op is accepted in the same cycle with no bubble.
- Flush mid-CALC at cycle 10 of a DIV, with in_valid also high → out_valid never rises, the op is not accepted, and the stage is IDLE next cycle. A following MUL 3 × 4 returns 12.
- Parametrised run: XLEN = 16, MUL_STEP = 16 → MULHU 0xFFFF × 0xFFFF = 0xFFFE with 2-cycle latency; reset asserted mid-DIV → IDLE with exu_rd = 0 next cycle.

Source files
------------

// File: rtl/exu_md_pkg.sv
// Shared types and funct3 decode helpers for the execute stage and its
// iterative multiply/divide datapath.
package exu_md_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_funct_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } exu_state_e;

    function automatic logic is_div(logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_signed_a(logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic is_signed_b(logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/exu_md_iter.sv
// Iterative RV32M datapath: MUL_STEP-bit shift-add multiplier and a restoring
// divider sharing one 2*XLEN accumulator, with sign fix-up and early cases.
module exu_md_iter
    import exu_md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEP  = 4,
    parameter int DIV_EARLY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            kill,
    input  logic            start,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      fn_q, fn_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   opb_q, opb_d;
    logic [XLEN-1:0] mpl_q, mpl_d;
    logic [XLEN-1:0] a_q, a_d;
    logic            dz_q, dz_d, ovf_q, ovf_d, qneg_q, qneg_d, rneg_q, rneg_d;

    logic            sa, sb, dz, ovf, early, last;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem, dsor;
    logic [XLEN:0]   dtmp;

    always_comb begin
        sa    = is_signed_a(funct) & a[XLEN-1];
        sb    = is_signed_b(funct) & b[XLEN-1];
        a_mag = sa ? -a : a;
        b_mag = sb ? -b : b;
        dz    = (b == '0);
        ovf   = is_signed_a(funct) & (a == SMIN) & (b == '1);
        early = (DIV_EARLY != 0) & is_div(funct) & (dz | ovf);
    end

    assign last = busy_q & (cnt_q == (is_div(fn_q) ? DIV_LAST : MUL_LAST));
    assign done = (start & early) | last;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        fn_d   = fn_q;
        acc_d  = acc_q;
        opb_d  = opb_q;
        mpl_d  = mpl_q;
        a_d    = a_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        quo    = acc_q[XLEN-1:0];
        rem    = acc_q[PW-1:XLEN];
        dsor   = opb_q[XLEN-1:0];
        dtmp   = {rem, quo[XLEN-1]};
        if (kill) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            busy_d = ~early;
            cnt_d  = '0;
            fn_d   = funct;
            a_d    = a;
            dz_d   = dz;
            ovf_d  = ovf;
            qneg_d = sa ^ sb;
            rneg_d = sa;
            mpl_d  = b;
            if (is_div(funct)) begin
                acc_d = {{XLEN{1'b0}}, a_mag};
                opb_d = {{XLEN{1'b0}}, b_mag};
            end else begin
                // A negative multiplier's sign bit weighs -2^XLEN: pre-load that term.
                acc_d = sb ? PW'(0) - {a, {XLEN{1'b0}}} : '0;
                opb_d = {{XLEN{sa}}, a};
            end
        end else if (busy_q) begin
            cnt_d  = cnt_q + 1'b1;
            busy_d = ~last;
            if (is_div(fn_q)) begin
                if (dtmp >= {1'b0, dsor})
                    acc_d = {dtmp[XLEN-1:0] - dsor, quo[XLEN-2:0], 1'b1};
                else
                    acc_d = {dtmp[XLEN-1:0], quo[XLEN-2:0], 1'b0};
            end else begin
                acc_d = acc_q + opb_q * {{(PW-MUL_STEP){1'b0}}, mpl_q[MUL_STEP-1:0]};
                opb_d = opb_q << MUL_STEP;
                mpl_d = mpl_q >> MUL_STEP;
            end
        end
    end

    // Boundary results override the iterated value so DIV_EARLY only changes latency.
    always_comb begin
        result = acc_q[XLEN-1:0];
        if (!is_div(fn_q))
            result = (fn_q == MD_MUL) ? acc_q[XLEN-1:0] : acc_q[PW-1:XLEN];
        else if (dz_q)
            result = fn_q[1] ? a_q : '1;
        else if (ovf_q)
            result = fn_q[1] ? '0 : a_q;
        else if (fn_q[1])
            result = rneg_q ? -rem : rem;
        else
            result = qneg_q ? -quo : quo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
        fn_q   <= fn_d;
        acc_q  <= acc_d;
        opb_q  <= opb_d;
        mpl_q  <= mpl_d;
        a_q    <= a_d;
        dz_q   <= dz_d;
        ovf_q  <= ovf_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

endmodule

// File: rtl/exu_md_stage.sv
// One-entry execute stage between IDU and WBU: pass-through results or
// iterative RV32M ops, with valid/ready on both sides, flush and pending rd.
module exu_md_stage
    import exu_md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEP  = 4,
    parameter int DIV_EARLY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_md,
    input  logic [2:0]      in_funct,
    input  logic [XLEN-1:0] in_val_a,
    input  logic [XLEN-1:0] in_val_b,
    input  logic [4:0]      in_rd,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wdata,
    output logic [4:0]      exu_rd
);
    exu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pass_q, pass_d;
    logic [4:0]      rd_q, rd_d;
    logic            md_q, md_d;
    logic            accept, md_done;
    logic [XLEN-1:0] md_result;

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    exu_md_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP),
        .DIV_EARLY(DIV_EARLY)
    ) u_iter (
        .clock (clock),
        .reset (reset),
        .kill  (flush),
        .start (accept & in_md),
        .funct (in_funct),
        .a     (in_val_a),
        .b     (in_val_b),
        .done  (md_done),
        .result(md_result)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        md_d    = md_q;
        pass_d  = pass_q;
        if (accept) begin
            pc_d   = in_pc;
            rd_d   = in_rd;
            md_d   = in_md;
            pass_d = in_val_a;
        end
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = (in_md & ~md_done) ? CALC : DONE;
                CALC: if (md_done) state_d = DONE;
                DONE: if (out_ready)
                          state_d = accept ? ((in_md & ~md_done) ? CALC : DONE) : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == DONE) & ~flush;
    assign out_pc    = pc_q;
    assign out_rd    = rd_q;
    assign out_wdata = md_q ? md_result : pass_q;
    assign exu_rd    = (state_q != IDLE) ? rd_q : 5'd0;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
        pc_q   <= pc_d;
        rd_q   <= rd_d;
        md_q   <= md_d;
        pass_q <= pass_d;
    end

endmodule

// File: tb/tb_exu_md_stage.sv
// Bench for exu_md_stage: cycle-level reference model for the default-size
// instance plus directed vectors, and a 16-bit single-step instance.
module tb_exu_md_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, in_md = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = 32'h0, in_val_a = 32'h0, in_val_b = 32'h0;
    logic [2:0]  in_funct = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_wdata;
    logic [4:0]  out_rd, exu_rd;

    logic        rst_h = 1'b1, in_valid_h = 1'b0, in_md_h = 1'b0, out_ready_h = 1'b0;
    logic [15:0] in_pc_h = 16'h0, in_val_a_h = 16'h0, in_val_b_h = 16'h0;
    logic [2:0]  in_funct_h = 3'd0;
    logic [4:0]  in_rd_h = 5'd0;
    logic        in_ready_h, out_valid_h;
    logic [15:0] out_pc_h, out_wdata_h;
    logic [4:0]  out_rd_h, exu_rd_h;

    exu_md_stage dut (
        .clock(clock), .reset(reset), .flush(flush), .in_ready(in_ready),
        .in_valid(in_valid), .in_pc(in_pc), .in_md(in_md), .in_funct(in_funct),
        .in_val_a(in_val_a), .in_val_b(in_val_b), .in_rd(in_rd),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_rd(out_rd), .out_wdata(out_wdata), .exu_rd(exu_rd)
    );

    exu_md_stage #(.XLEN(16), .MUL_STEP(16), .DIV_EARLY(1)) dut_h (
        .clock(clock), .reset(rst_h), .flush(1'b0), .in_ready(in_ready_h),
        .in_valid(in_valid_h), .in_pc(in_pc_h), .in_md(in_md_h), .in_funct(in_funct_h),
        .in_val_a(in_val_a_h), .in_val_b(in_val_b_h), .in_rd(in_rd_h),
        .out_ready(out_ready_h), .out_valid(out_valid_h), .out_pc(out_pc_h),
        .out_rd(out_rd_h), .out_wdata(out_wdata_h), .exu_rd(exu_rd_h)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the RV M definitions, in wide signed math.
    function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a_in,
                                           input logic [31:0] b_in, input int xlen);
        logic [31:0]        m, a, b;
        logic               sga, sgb;
        logic signed [127:0] av, bv, r, smin;
        m   = (xlen == 32) ? 32'hFFFF_FFFF : ((32'd1 << xlen) - 32'd1);
        a   = a_in & m;
        b   = b_in & m;
        sga = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
        sgb = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
        av  = $signed({96'd0, a});
        bv  = $signed({96'd0, b});
        if (sga && a[xlen-1]) av = av - (128'sd1 <<< xlen);
        if (sgb && b[xlen-1]) bv = bv - (128'sd1 <<< xlen);
        if (f < 3'd4) begin
            r = av * bv;
            if (f != 3'd0) r = r >>> xlen;
            return r[31:0] & m;
        end
        if (b == 32'd0) return f[1] ? a : m;
        smin = -(128'sd1 <<< (xlen - 1));
        if (sga && av == smin && bv == -128'sd1) return f[1] ? 32'd0 : a;
        r = f[1] ? (av % bv) : (av / bv);
        return r[31:0] & m;
    endfunction

    function automatic int lat_ref(input logic md, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!md) return 1;
        if (!f[2]) return 9;
        if (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Model of the default instance: one slot, a countdown to result, a consume rule.
    logic        m_live = 1'b0, m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res = 32'h0, m_pc = 32'h0;
    logic [4:0]  m_rd = 5'd0;
    logic        e_rdy, e_ov;

    always @(posedge clock) begin
        if (reset) begin
            m_live <= 1'b1;
            m_busy <= 1'b0;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else begin
            if (m_busy) begin
                if (m_wait > 0) m_wait <= m_wait - 1;
                else if (out_ready) m_busy <= 1'b0;
            end
            if (in_valid && (!m_busy || (m_wait == 0 && out_ready))) begin
                m_busy <= 1'b1;
                m_wait <= lat_ref(in_md, in_funct, in_val_a, in_val_b) - 1;
                m_res  <= in_md ? md_ref(in_funct, in_val_a, in_val_b, 32) : in_val_a;
                m_pc   <= in_pc;
                m_rd   <= in_rd;
            end
        end
    end

    always @(negedge clock) begin
        if (m_live && !reset) begin
            e_rdy = !m_busy || (m_wait == 0 && out_ready);
            e_ov  = m_busy && m_wait == 0 && !flush;
            chk("model in_ready", 32'(in_ready), 32'(e_rdy));
            chk("model out_valid", 32'(out_valid), 32'(e_ov));
            chk("model exu_rd", 32'(exu_rd), m_busy ? 32'(m_rd) : 32'd0);
            if (e_ov) begin
                chk("model out_wdata", out_wdata, m_res);
                chk("model out_rd", 32'(out_rd), 32'(m_rd));
                chk("model out_pc", out_pc, m_pc);
            end
        end
    end

    task automatic drive(input logic md, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1;
        in_md    = md;
        in_funct = f;
        in_val_a = a;
        in_val_b = b;
        in_rd    = rd;
        in_pc    = in_pc + 32'd4;
    endtask

    task automatic wait_out(output int lat, output logic [31:0] w, output logic [4:0] r,
                            output logic [4:0] x);
        lat = 1;
        @(negedge clock);
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (!out_valid) chk("out_valid timeout", 32'(out_valid), 32'd1);
        w = out_wdata;
        r = out_rd;
        x = exu_rd;
    endtask

    task automatic run_op(input string nm, input logic md, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int explat);
        int lat;
        logic [31:0] w;
        logic [4:0] r, x;
        drive(md, f, a, b, rd);
        @(posedge clock);
        #1 in_valid = 1'b0;
        wait_out(lat, w, r, x);
        chk({nm, " latency"}, 32'(lat), 32'(explat));
        chk({nm, " wdata"}, w, exp);
        chk({nm, " out_rd"}, 32'(r), 32'(rd));
        chk({nm, " exu_rd"}, 32'(x), 32'(rd));
        @(posedge clock);
        #1;
    endtask

    task automatic run_h(input string nm, input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp, input int explat);
        int lat;
        in_valid_h = 1'b1;
        in_md_h    = 1'b1;
        in_funct_h = f;
        in_val_a_h = a;
        in_val_b_h = b;
        in_rd_h    = 5'd7;
        @(posedge clock);
        #1 in_valid_h = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!out_valid_h && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, " out_valid"}, 32'(out_valid_h), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(explat));
        chk({nm, " wdata"}, 32'(out_wdata_h), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, seen;
        logic [31:0] w, a, b;
        logic [4:0] r, x;
        logic [2:0] f;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        rst_h = 1'b0;
        out_ready = 1'b1;
        out_ready_h = 1'b1;
        @(negedge clock);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset exu_rd", 32'(exu_rd), 32'd0);
        chk("reset h exu_rd", 32'(exu_rd_h), 32'd0);
        @(posedge clock);
        #1;

        run_op("pass", 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h1234, 1);
        @(negedge clock);
        chk("pass exu_rd after", 32'(exu_rd), 32'd0);
        @(posedge clock);
        #1;

        run_op("mulh", 1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 9);
        run_op("mulhsu", 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 9);
        run_op("mul", 1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 9);
        run_op("mulhu", 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 9);
        run_op("div", 1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
        run_op("rem", 1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
        run_op("divu by 0", 1'b1, 3'd5, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op("rem ovf", 1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1);
        run_op("div ovf", 1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_op("rem by 0", 1'b1, 3'd6, 32'hFFFF_FFF9, 32'd0, 5'd11, 32'hFFFF_FFF9, 1);
        run_op("remu", 1'b1, 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 33);

        for (int i = 0; i < 6; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            run_op("table", 1'b1, f, a, b, 5'(i + 16), md_ref(f, a, b, 32), lat_ref(1'b1, f, a, b));
        end

        out_ready = 1'b0;
        drive(1'b1, 3'd4, 32'd100, 32'd7, 5'd12);
        @(posedge clock);
        #1 in_valid = 1'b0;
        wait_out(lat, w, r, x);
        chk("bp div latency", 32'(lat), 32'd33);
        chk("bp div wdata", w, 32'd14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp hold wdata", out_wdata, w);
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold rd", 32'(out_rd), 32'd12);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'd3, 32'd5, 5'd13);
        @(negedge clock);
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        wait_out(lat, w, r, x);
        chk("b2b mul latency", 32'(lat), 32'd9);
        chk("b2b mul wdata", w, 32'd15);
        @(posedge clock);
        #1;

        drive(1'b1, 3'd4, 32'd1000, 32'd3, 5'd14);
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        flush = 1'b1;
        drive(1'b1, 3'd0, 32'd1, 32'd1, 5'd20);
        @(negedge clock);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("flush idle exu_rd", 32'(exu_rd), 32'd0);
        chk("flush idle in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        chk("flush no result", 32'(seen), 32'd0);
        @(posedge clock);
        #1;
        run_op("mul after flush", 1'b1, 3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 9);

        run_h("h mulhu", 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 2);
        run_h("h div", 3'd4, 16'hFFF9, 16'h0002, 16'hFFFD, 17);
        run_h("h div ovf", 3'd4, 16'h8000, 16'hFFFF, 16'h8000, 1);
        in_valid_h = 1'b1;
        in_funct_h = 3'd4;
        in_val_a_h = 16'd100;
        in_val_b_h = 16'd3;
        in_rd_h    = 5'd9;
        @(posedge clock);
        #1 in_valid_h = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        chk("h mid-div exu_rd", 32'(exu_rd_h), 32'd9);
        @(posedge clock);
        #1 rst_h = 1'b1;
        @(posedge clock);
        #1 rst_h = 1'b0;
        @(negedge clock);
        chk("h reset exu_rd", 32'(exu_rd_h), 32'd0);
        chk("h reset out_valid", 32'(out_valid_h), 32'd0);
        chk("h reset in_ready", 32'(in_ready_h), 32'd1);
        @(posedge clock);
        #1;
        run_h("h mul after reset", 3'd0, 16'd300, 16'd300, 16'h5F90, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
